// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam logic [31:0] EXC_HANDLER_PC = 32'h0000_4180;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    S_RUN      = 1'b0,
    S_EXC_PEND = 1'b1
  } state_t;

endpackage

// File: rtl/md_busy_ctr.sv
// Mult/div busy counter. Loads the op latency on an accepted start, otherwise
// counts down to zero. md_err is set on a start seen while busy.
// Ports: clk/res, start (accepted start), is_div (latency select),
//        err_set (start while busy), md_busy, md_err (sticky).
module md_busy_ctr
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic res,
  input  logic start,
  input  logic is_div,
  input  logic err_set,
  output logic md_busy,
  output logic md_err
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  assign md_busy = (cnt_q != '0);

  // Older ops always run to completion: decrement is never gated by stalls.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q  <= '0;
      md_err <= 1'b0;
    end else begin
      if (start) begin
        cnt_q <= is_div ? DIV_LOAD : MULT_LOAD;
      end else if (md_busy) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (err_set) begin
        md_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: register enables,
// bubble inserts, exception/eret redirects held across bus stalls, and the
// mult/div busy guard for HI/LO.
// Ports: clk/res; hazard inputs D_stall_data, D_md_use; mult/div start
//        E_md_start/E_md_is_div; redirect events M_exc_req/M_eret; ext_stall;
//        outputs *_WE, *_flush, pc_redirect, pc_sel_epc, md_busy, md_err.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic res,
  input  logic D_stall_data,
  input  logic D_md_use,
  input  logic E_md_start,
  input  logic E_md_is_div,
  input  logic M_exc_req,
  input  logic M_eret,
  input  logic ext_stall,
  output logic PC_WE,
  output logic D_WE,
  output logic E_WE,
  output logic M_WE,
  output logic W_WE,
  output logic D_flush,
  output logic E_flush,
  output logic M_flush,
  output logic W_flush,
  output logic pc_redirect,
  output logic pc_sel_epc,
  output logic md_busy,
  output logic md_err
);

  state_t state_q, state_d;
  logic   pend_eret_q, pend_eret_d;
  logic   redirect_evt;
  logic   hazard_stall;
  logic   md_start_acc;
  logic   md_err_set;

  assign redirect_evt = M_exc_req | M_eret;
  assign hazard_stall = D_stall_data | (D_md_use & (md_busy | E_md_start));

  // A start in the redirect cycle belongs to a flushed (younger) instruction.
  assign md_start_acc = E_md_start & ~md_busy & ~pc_redirect & ~ext_stall &
                        (state_q == S_RUN);
  assign md_err_set   = E_md_start & md_busy & ~pc_redirect;

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= S_RUN;
      pend_eret_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_eret_q <= pend_eret_d;
    end
  end

  // Next state: park a redirect that arrives under a bus stall
  always_comb begin
    state_d     = state_q;
    pend_eret_d = pend_eret_q;
    case (state_q)
      S_RUN: begin
        if (redirect_evt && ext_stall) begin
          state_d     = S_EXC_PEND;
          pend_eret_d = M_eret & ~M_exc_req;
        end
      end
      S_EXC_PEND: begin
        if (!ext_stall) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Enable/flush decode; reset forces the free-running pattern
  always_comb begin
    PC_WE       = 1'b1;
    D_WE        = 1'b1;
    E_WE        = 1'b1;
    M_WE        = 1'b1;
    W_WE        = 1'b1;
    D_flush     = 1'b0;
    E_flush     = 1'b0;
    M_flush     = 1'b0;
    W_flush     = 1'b0;
    pc_redirect = 1'b0;
    pc_sel_epc  = 1'b0;
    if (!res) begin
      if ((state_q == S_EXC_PEND) || redirect_evt || ext_stall) begin
        if (ext_stall) begin
          {PC_WE, D_WE, E_WE, M_WE, W_WE} = 5'b00000;
        end else begin
          // Redirect: M never commits, every stage gets a bubble.
          {D_flush, E_flush, M_flush, W_flush} = 4'b1111;
          pc_redirect = 1'b1;
          pc_sel_epc  = (state_q == S_EXC_PEND) ? pend_eret_q
                                                : (M_eret & ~M_exc_req);
        end
      end else if (hazard_stall) begin
        PC_WE   = 1'b0;
        D_WE    = 1'b0;
        E_flush = 1'b1;
      end
    end
  end

  md_busy_ctr #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_busy_ctr (
    .clk    (clk),
    .res    (res),
    .start  (md_start_acc),
    .is_div (E_md_is_div),
    .err_set(md_err_set),
    .md_busy(md_busy),
    .md_err (md_err)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic res;
  logic D_stall_data, D_md_use, E_md_start, E_md_is_div;
  logic M_exc_req, M_eret, ext_stall;
  logic PC_WE, D_WE, E_WE, M_WE, W_WE;
  logic D_flush, E_flush, M_flush, W_flush;
  logic pc_redirect, pc_sel_epc, md_busy, md_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .res(res),
    .D_stall_data(D_stall_data), .D_md_use(D_md_use),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
    .M_exc_req(M_exc_req), .M_eret(M_eret), .ext_stall(ext_stall),
    .PC_WE(PC_WE), .D_WE(D_WE), .E_WE(E_WE), .M_WE(M_WE), .W_WE(W_WE),
    .D_flush(D_flush), .E_flush(E_flush), .M_flush(M_flush), .W_flush(W_flush),
    .pc_redirect(pc_redirect), .pc_sel_epc(pc_sel_epc),
    .md_busy(md_busy), .md_err(md_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Compare enables, flushes and redirect controls in one go.
  task automatic chk_ctl(input string tag, input logic [4:0] we, input logic [3:0] fl,
                         input logic redir, input logic sel);
    chk({tag, ".we"}, {3'b000, PC_WE, D_WE, E_WE, M_WE, W_WE}, {3'b000, we});
    chk({tag, ".fl"}, {4'b0000, D_flush, E_flush, M_flush, W_flush}, {4'b0000, fl});
    chk({tag, ".redir"}, {7'b0, pc_redirect}, {7'b0, redir});
    if (redir) chk({tag, ".sel"}, {7'b0, pc_sel_epc}, {7'b0, sel});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    D_stall_data = 0; D_md_use = 0; E_md_start = 0; E_md_is_div = 0;
    M_exc_req = 0; M_eret = 0; ext_stall = 0;
  endtask

  initial begin
    res = 1'b1;
    clr();
    #1;
    chk_ctl("reset", 5'b11111, 4'b0000, 1'b0, 1'b0);
    chk("reset.busy", {7'b0, md_busy}, 8'd0);
    chk("reset.err", {7'b0, md_err}, 8'd0);
    tick();
    res = 1'b0;
    tick();

    // Plain data hazard
    D_stall_data = 1; #1;
    chk_ctl("hazard", 5'b00111, 4'b0100, 1'b0, 1'b0);
    tick(); clr(); #1;
    chk_ctl("run", 5'b11111, 4'b0000, 1'b0, 1'b0);

    // Mult then mfhi: stall in start cycle plus 5 busy cycles
    E_md_start = 1; E_md_is_div = 0; D_md_use = 1; #1;
    chk_ctl("mult.c0", 5'b00111, 4'b0100, 1'b0, 1'b0);
    chk("mult.c0.busy", {7'b0, md_busy}, 8'd0);
    tick(); E_md_start = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("mult.busy", {7'b0, md_busy}, 8'd1);
      chk_ctl("mult.stall", 5'b00111, 4'b0100, 1'b0, 1'b0);
      tick();
    end
    #1;
    chk("mult.done", {7'b0, md_busy}, 8'd0);
    chk_ctl("mult.release", 5'b11111, 4'b0000, 1'b0, 1'b0);
    clr(); tick();

    // Div: 10 busy cycles; a second div start at busy cycle 5 is ignored
    E_md_start = 1; E_md_is_div = 1; tick();
    for (int i = 0; i < 10; i++) begin
      E_md_start = (i == 4); #1;
      chk("div.busy", {7'b0, md_busy}, 8'd1);
      chk("div.err", {7'b0, md_err}, (i > 4) ? 8'd1 : 8'd0);
      tick();
    end
    E_md_start = 0; #1;
    chk("div.done", {7'b0, md_busy}, 8'd0);
    chk("div.err.sticky", {7'b0, md_err}, 8'd1);
    clr(); tick();

    // Start under bus stall is not accepted
    E_md_start = 1; ext_stall = 1; #1;
    chk_ctl("stall.only", 5'b00000, 4'b0000, 1'b0, 1'b0);
    tick(); clr(); #1;
    chk("stall.start", {7'b0, md_busy}, 8'd0);

    // Exception applied immediately; same-cycle mult start suppressed
    M_exc_req = 1; E_md_start = 1; #1;
    chk_ctl("exc", 5'b11111, 4'b1111, 1'b1, 1'b0);
    tick(); clr(); #1;
    chk("exc.nostart", {7'b0, md_busy}, 8'd0);
    chk_ctl("exc.after", 5'b11111, 4'b0000, 1'b0, 1'b0);

    // Exception under 3 stalled cycles; inputs ignored while pending
    M_exc_req = 1; ext_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctl("excp.hold", 5'b00000, 4'b0000, 1'b0, 1'b0);
      tick();
      M_exc_req = 0; M_eret = 1;
    end
    ext_stall = 0; #1;
    chk_ctl("excp.apply", 5'b11111, 4'b1111, 1'b1, 1'b0);
    tick(); clr(); #1;
    chk_ctl("excp.run", 5'b11111, 4'b0000, 1'b0, 1'b0);

    // Eret under one stalled cycle
    M_eret = 1; ext_stall = 1; #1;
    chk_ctl("eretp.hold", 5'b00000, 4'b0000, 1'b0, 1'b0);
    tick(); clr(); #1;
    chk_ctl("eretp.apply", 5'b11111, 4'b1111, 1'b1, 1'b1);
    tick();

    // Priority of exception over eret, eret alone
    M_exc_req = 1; M_eret = 1; #1;
    chk_ctl("both", 5'b11111, 4'b1111, 1'b1, 1'b0);
    tick(); clr(); M_eret = 1; #1;
    chk_ctl("eret", 5'b11111, 4'b1111, 1'b1, 1'b1);
    tick(); clr();

    // Async reset with counter at 3
    E_md_start = 1; tick(); E_md_start = 0; tick(); tick();
    #1;
    chk("pre_rst.busy", {7'b0, md_busy}, 8'd1);
    D_stall_data = 1; M_exc_req = 1; res = 1; #1;
    chk("rst.busy", {7'b0, md_busy}, 8'd0);
    chk_ctl("rst.ctl", 5'b11111, 4'b0000, 1'b0, 1'b0);
    tick(); clr(); res = 0; #1;
    chk_ctl("rst.release", 5'b11111, 4'b0000, 1'b0, 1'b0);
    chk("rst.err", {7'b0, md_err}, 8'd0);
    tick(); #1;
    chk("rst.busy2", {7'b0, md_busy}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
